// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding and compile-time helpers for
// baud division, counter sizing and 3-sample majority voting.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_e;

    // Rounded clocks-per-tick divisor; never below one clock.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int denom;
        int div;
        denom = baud * os;
        div   = (clk_hz + (denom / 2)) / denom;
        return (div < 1) ? 1 : div;
    endfunction

    // Width of a counter that must hold values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Majority of three line samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, restartable
// through a synchronous clear so the sample phase can be aligned to a start edge.
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Next divider count and tick pulse; clear restarts the period.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d  = {CW{1'b0}};
            tick_d = 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_d  = {CW{1'b0}};
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Divider state and registered tick output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= {CW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receive path: synchronises rxd, aligns oversampling to the start edge,
// majority-votes each bit mid-period and hands completed words to a one-entry
// holding register read by the host through rd.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int SYSTEM_CLK_HZ = 100_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int DATA_WIDTH    = 8,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int            DIV      = calc_div(SYSTEM_CLK_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int            SW       = cnt_width(OVERSAMPLE);
    localparam int            BW       = cnt_width(DATA_WIDTH);
    localparam logic [SW-1:0] SMP_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_C    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    // Synchroniser and edge-detect registers
    logic rxd_meta_q, rxd_meta_d;
    logic rxd_sync_q, rxd_sync_d;
    logic rxd_prev_q, rxd_prev_d;

    // FSM and datapath registers
    uart_state_e           state_q, state_d;
    logic [SW-1:0]         sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;

    // Holding register and status outputs
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;

    // Combinational control
    logic tick_s;
    logic start_edge_s;
    logic tick_clr_s;
    logic bit_val_s;
    logic decide_s;
    logic bit_end_s;
    logic accept_s;
    logic frame_err_s;
    logic shift_en_s;
    logic rd_take_s;

    assign start_edge_s = rxd_prev_q & ~rxd_sync_q;
    assign tick_clr_s   = (state_q == ST_IDLE) & start_edge_s;
    assign bit_val_s    = majority3(samp_q[0], samp_q[1], rxd_sync_q);
    assign decide_s     = tick_s & (sample_cnt_q == SMP_C);
    assign bit_end_s    = tick_s & (sample_cnt_q == SMP_LAST);
    assign rd_take_s    = rd & valid_q;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr_s),
        .tick (tick_s)
    );

    // Two-flop synchroniser followed by a delayed copy for falling-edge detect.
    always_comb begin
        rxd_meta_d = rxd;
        rxd_sync_d = rxd_meta_q;
        rxd_prev_d = rxd_sync_q;
    end

    // Synchroniser registers idle high so reset does not fake a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_meta_d;
            rxd_sync_q <= rxd_sync_d;
            rxd_prev_q <= rxd_prev_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; STOP returns to IDLE at the decision point so a
    // following start bit can be caught without waiting for the bit end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) state_d = ST_START;
                else              state_d = ST_IDLE;
            end
            ST_START: begin
                if (decide_s && bit_val_s) state_d = ST_IDLE;
                else if (bit_end_s)        state_d = ST_DATA;
                else                       state_d = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_cnt_q == BIT_LAST)) state_d = ST_STOP;
                else                                      state_d = ST_DATA;
            end
            ST_STOP: begin
                if (decide_s) state_d = bit_val_s ? ST_IDLE : ST_WAIT_IDLE;
                else          state_d = ST_STOP;
            end
            ST_WAIT_IDLE: begin
                if (tick_s && rxd_sync_q && (sample_cnt_q == SMP_LAST)) state_d = ST_IDLE;
                else                                                    state_d = ST_WAIT_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: word accept, framing error and data-bit shift strobes.
    always_comb begin
        accept_s    = 1'b0;
        frame_err_s = 1'b0;
        shift_en_s  = 1'b0;
        case (state_q)
            ST_DATA: shift_en_s = decide_s;
            ST_STOP: begin
                accept_s    = decide_s & bit_val_s;
                frame_err_s = decide_s & ~bit_val_s;
            end
            default: begin
                accept_s    = 1'b0;
                frame_err_s = 1'b0;
                shift_en_s  = 1'b0;
            end
        endcase
    end

    // Sample/bit counters, vote samples and shift register. In WAIT_IDLE the
    // sample counter measures continuous high time and restarts on any low.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;

        if (tick_clr_s || frame_err_s) begin
            sample_cnt_d = {SW{1'b0}};
        end else if (state_q == ST_WAIT_IDLE) begin
            if (!rxd_sync_q)  sample_cnt_d = {SW{1'b0}};
            else if (tick_s)  sample_cnt_d = sample_cnt_q + SW'(1);
            else              sample_cnt_d = sample_cnt_q;
        end else if (tick_s) begin
            if (sample_cnt_q == SMP_LAST) sample_cnt_d = {SW{1'b0}};
            else                          sample_cnt_d = sample_cnt_q + SW'(1);
        end else begin
            sample_cnt_d = sample_cnt_q;
        end

        if (state_q != ST_DATA) begin
            bit_cnt_d = {BW{1'b0}};
        end else if (bit_end_s) begin
            if (bit_cnt_q == BIT_LAST) bit_cnt_d = {BW{1'b0}};
            else                       bit_cnt_d = bit_cnt_q + BW'(1);
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        if (tick_s && (sample_cnt_q == SMP_A))      samp_d[0] = rxd_sync_q;
        else if (tick_s && (sample_cnt_q == SMP_B)) samp_d[1] = rxd_sync_q;
        else                                        samp_d    = samp_q;

        if (shift_en_s) shift_d = {bit_val_s, shift_q[DATA_WIDTH-1:1]};
        else            shift_d = shift_q;
    end

    // Receive datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt_q <= {SW{1'b0}};
            bit_cnt_q    <= {BW{1'b0}};
            samp_q       <= 2'b00;
            shift_q      <= {DATA_WIDTH{1'b0}};
        end else begin
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
        end
    end

    // Holding register: a read in the accept cycle consumes the old word, so
    // overrun only flags a word overwritten while still unread.
    always_comb begin
        dout_d      = dout_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_s;
        if (accept_s) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rd) overrun_d = 1'b1;
            else                overrun_d = 1'b0;
        end else if (rd_take_s) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            dout_d    = dout_q;
            valid_d   = valid_q;
            overrun_d = overrun_q;
        end
    end

    // Registered host-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q      <= {DATA_WIDTH{1'b0}};
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
